// File: rtl/frame_fifo_sc.sv
// Single-clock frame FIFO: assembles per-channel ADC words into frames, queues them,
// and presents the head frame show-ahead with a registered output.
module frame_fifo_sc #(
  parameter int NCH   = 8,
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic              SAMPLE_CLK,
  input  logic              NRST_sync,
  input  logic              ENSAMP_sync,
  input  logic [W-1:0]      RESULT,
  input  logic              DONE,
  input  logic [NCH-1:0]    ATMCHSEL,
  input  logic              LASTWORD,
  input  logic              FIFO_POP,
  input  logic [LW-1:0]     FIFOWATERMARK,
  input  logic              OVF_MODE,
  output logic [NCH*W-1:0]  ADC_data,
  output logic              FRAME_VALID,
  output logic [LW-1:0]     FIFO_LEVEL,
  output logic              DATA_RDY,
  output logic              FIFO_OVERFLOW,
  output logic              FIFO_UNDERFLOW,
  output logic              CHSEL_ERR,
  output logic [7:0]        OVF_COUNT
);

  localparam int AW = LW - 1;
  localparam int FW = NCH * W;

  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] stage_q;
  logic [FW-1:0] stage_merged;
  logic [FW-1:0] head_nxt;
  logic          valid_nxt;

  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] wr_nxt;
  logic [LW-1:0] rd_nxt;
  logic [LW-1:0] level_nxt;

  logic sel_onehot;
  logic word_ok;
  logic commit;
  logic fifo_empty;
  logic fifo_full;
  logic pop_ok;
  logic pop_empty;
  logic ovf_hit;
  logic do_write;

  assign sel_onehot = (ATMCHSEL != '0) && ((ATMCHSEL & (ATMCHSEL - NCH'(1))) == '0);
  assign word_ok    = DONE && sel_onehot;
  assign commit     = DONE && LASTWORD;

  assign fifo_empty = (FIFO_LEVEL == '0);
  assign fifo_full  = (FIFO_LEVEL == LW'(DEPTH));
  assign pop_ok     = FIFO_POP && !fifo_empty;
  assign pop_empty  = FIFO_POP && fifo_empty;

  // A pop in the same cycle frees the slot, so only an unpopped full FIFO overflows.
  assign ovf_hit    = commit && fifo_full && !pop_ok;
  assign do_write   = commit && (!ovf_hit || OVF_MODE);

  assign wr_nxt     = do_write ? wr_ptr + LW'(1) : wr_ptr;
  assign rd_nxt     = (pop_ok || (ovf_hit && OVF_MODE)) ? rd_ptr + LW'(1) : rd_ptr;
  assign level_nxt  = wr_nxt - rd_nxt;

  always_comb begin
    stage_merged = stage_q;
    for (int k = 0; k < NCH; k++) begin
      if (word_ok && ATMCHSEL[k]) begin
        stage_merged[k*W +: W] = RESULT;
      end
    end
  end

  // Head after the edge; bypass when the frame being written lands at the new read slot.
  always_comb begin
    valid_nxt = (level_nxt != '0);
    head_nxt  = '0;
    if (valid_nxt) begin
      if (do_write && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0])) begin
        head_nxt = stage_merged;
      end else begin
        head_nxt = mem[rd_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (ENSAMP_sync && do_write) begin
      mem[wr_ptr[AW-1:0]] <= stage_merged;
    end
  end

  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      stage_q        <= '0;
      ADC_data       <= '0;
      FRAME_VALID    <= 1'b0;
      FIFO_LEVEL     <= '0;
      FIFO_OVERFLOW  <= 1'b0;
      FIFO_UNDERFLOW <= 1'b0;
      CHSEL_ERR      <= 1'b0;
      OVF_COUNT      <= '0;
    end else if (!ENSAMP_sync) begin
      // Flush keeps OVF_COUNT so software can still read the history.
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      stage_q        <= '0;
      ADC_data       <= '0;
      FRAME_VALID    <= 1'b0;
      FIFO_LEVEL     <= '0;
      FIFO_OVERFLOW  <= 1'b0;
      FIFO_UNDERFLOW <= 1'b0;
      CHSEL_ERR      <= 1'b0;
    end else begin
      wr_ptr         <= wr_nxt;
      rd_ptr         <= rd_nxt;
      FIFO_LEVEL     <= level_nxt;
      ADC_data       <= head_nxt;
      FRAME_VALID    <= valid_nxt;
      stage_q        <= commit ? '0 : stage_merged;
      FIFO_OVERFLOW  <= ovf_hit;
      FIFO_UNDERFLOW <= pop_empty;
      CHSEL_ERR      <= DONE && !sel_onehot;
      if (ovf_hit && (OVF_COUNT != 8'hFF)) begin
        OVF_COUNT <= OVF_COUNT + 8'd1;
      end
    end
  end

  assign DATA_RDY = ENSAMP_sync && (FIFO_LEVEL >= FIFOWATERMARK);

endmodule
